// File: rtl/tq_pkg.sv
// Shared types and constants for the transform/quant chroma path.
package tq_pkg;
  localparam int COEFF_W      = 15;
  localparam int CHROMA_BLKS  = 8;
  localparam int ROWS_PER_BLK = 4;

  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef coeff_t [3:0]              row_t;
endpackage

// File: rtl/tq_dc_bank.sv
// One chroma DC bank: four raster-ordered coefficients plus a full flag.
module tq_dc_bank #(
  parameter int W = tq_pkg::COEFF_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [4*W-1:0]      wr_dc_i,
  input  logic                rel_i,
  input  logic [1:0]          rd_idx_i,
  output logic signed [W-1:0] rd_dc_o,
  output logic                full_o
);
  logic [4*W-1:0] dc_q;

  // A write and a release never target the same bank in one cycle; write wins regardless.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     full_o <= 1'b0;
    else if (clr_i)   full_o <= 1'b0;
    else if (wr_en_i) full_o <= 1'b1;
    else if (rel_i)   full_o <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) dc_q <= wr_dc_i;
  end

  assign rd_dc_o = $signed(dc_q[rd_idx_i*W +: W]);
endmodule

// File: rtl/tq_chromadc_merge.sv
// Merges buffered chroma DC coefficients into lane 0 of row 0 of each 4x4 AC block.
module tq_chromadc_merge #(
  parameter int COEFF_W = tq_pkg::COEFF_W,
  parameter int ROW_W   = 4*COEFF_W
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clr_i,
  input  logic                      dc_valid_i,
  output logic                      dc_ready_o,
  input  logic                      dc_comp_i,
  input  logic signed [COEFF_W-1:0] dc00_i,
  input  logic signed [COEFF_W-1:0] dc01_i,
  input  logic signed [COEFF_W-1:0] dc10_i,
  input  logic signed [COEFF_W-1:0] dc11_i,
  input  logic                      ac_valid_i,
  output logic                      ac_ready_o,
  input  logic [ROW_W-1:0]          ac_row_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ROW_W-1:0]          out_row_o,
  output logic [2:0]                out_blk_o,
  output logic [1:0]                out_ridx_o,
  output logic                      out_mb_last_o
);
  localparam logic [1:0] ROW_LAST   = 2'(tq_pkg::ROWS_PER_BLK - 1);
  localparam logic [2:0] BLK_LAST   = 3'(tq_pkg::CHROMA_BLKS - 1);
  localparam logic [2:0] BLK_CB_END = 3'(tq_pkg::CHROMA_BLKS/2 - 1);

  logic [2:0]                blk_cnt;
  logic [1:0]                row_cnt;
  logic                      comp;
  logic                      full_cb, full_cr, full_comp;
  logic                      dc_hs, ac_hs, row_last;
  logic                      rel_cb, rel_cr;
  logic signed [COEFF_W-1:0] dc_cb, dc_cr, dc_sel;
  logic [4*COEFF_W-1:0]      dc_set;

  logic                      vld_p1;
  logic [ROW_W-1:0]          row_p1;
  logic [2:0]                blk_p1;
  logic [1:0]                ridx_p1;
  logic                      last_p1;

  function automatic logic [ROW_W-1:0] merge_dc(input logic [ROW_W-1:0] row,
                                                input logic signed [COEFF_W-1:0] dc,
                                                input logic sub);
    merge_dc = row;
    if (sub) merge_dc[COEFF_W-1:0] = dc;
  endfunction

  assign comp       = blk_cnt[2];
  assign full_comp  = comp ? full_cr : full_cb;
  assign dc_ready_o = dc_comp_i ? !full_cr : !full_cb;
  assign ac_ready_o = (!vld_p1 || out_ready_i) && ((row_cnt != 2'd0) || full_comp);
  assign dc_hs      = dc_valid_i && dc_ready_o && !clr_i;
  assign ac_hs      = ac_valid_i && ac_ready_o && !clr_i;
  assign row_last   = (row_cnt == ROW_LAST);
  assign rel_cb     = ac_hs && row_last && (blk_cnt == BLK_CB_END);
  assign rel_cr     = ac_hs && row_last && (blk_cnt == BLK_LAST);
  assign dc_set     = {dc11_i, dc10_i, dc01_i, dc00_i};
  assign dc_sel     = comp ? dc_cr : dc_cb;

  tq_dc_bank #(.W(COEFF_W)) u_bank_cb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (clr_i),
    .wr_en_i  (dc_hs && !dc_comp_i),
    .wr_dc_i  (dc_set),
    .rel_i    (rel_cb),
    .rd_idx_i (blk_cnt[1:0]),
    .rd_dc_o  (dc_cb),
    .full_o   (full_cb)
  );

  tq_dc_bank #(.W(COEFF_W)) u_bank_cr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (clr_i),
    .wr_en_i  (dc_hs && dc_comp_i),
    .wr_dc_i  (dc_set),
    .rel_i    (rel_cr),
    .rd_idx_i (blk_cnt[1:0]),
    .rd_dc_o  (dc_cr),
    .full_o   (full_cr)
  );

  // Stage p0 -> p1: accepted AC row becomes the registered merged output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1  <= 1'b0;
      row_p1  <= '0;
      blk_p1  <= '0;
      ridx_p1 <= '0;
      last_p1 <= 1'b0;
      row_cnt <= '0;
      blk_cnt <= '0;
    end else if (clr_i) begin
      vld_p1  <= 1'b0;
      row_cnt <= '0;
      blk_cnt <= '0;
    end else if (ac_hs) begin
      vld_p1  <= 1'b1;
      row_p1  <= merge_dc(ac_row_i, dc_sel, row_cnt == 2'd0);
      blk_p1  <= blk_cnt;
      ridx_p1 <= row_cnt;
      last_p1 <= row_last && (blk_cnt == BLK_LAST);
      row_cnt <= row_last ? 2'd0 : row_cnt + 2'd1;
      if (row_last) blk_cnt <= (blk_cnt == BLK_LAST) ? 3'd0 : blk_cnt + 3'd1;
    end else if (out_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid_o   = vld_p1;
  assign out_row_o     = row_p1;
  assign out_blk_o     = blk_p1;
  assign out_ridx_o    = ridx_p1;
  assign out_mb_last_o = last_p1;
endmodule

// File: doc/tq_chromadc_merge.md
Name: tq_chromaDC_merge

Overview:
- Sits directly downstream of the chroma DC inverse-Hadamard/inverse-quant stage in the H.264 reconstruction path.
- Captures each 2x2 set of reconstructed chroma DC coefficients (Cb, then Cr) into a two-bank buffer.
- Streams the eight dequantized chroma 4x4 AC blocks row by row, substituting the matching DC coefficient into position [0][0] of each block.
- Output feeds the 4x4 inverse integer transform. Valid/ready handshakes on every side.

Parameters:
- COEFF_W, 15, signed coefficient width.
- ROW_W, 4*COEFF_W, width of one 4-coefficient row; lane c occupies bits [c*COEFF_W +: COEFF_W], column 0 at the LSBs.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear: banks and counters to reset state, out_valid_o low next cycle
- dc_valid_i  in  1  DC set valid
- dc_ready_o  out  1  DC set accepted when dc_valid_i & dc_ready_o
- dc_comp_i  in  1  0 = Cb, 1 = Cr
- dc00_i, dc01_i, dc10_i, dc11_i  in  COEFF_W each  signed DC coefficients, raster order
- ac_valid_i  in  1  AC row valid
- ac_ready_o  out  1  AC row accepted when ac_valid_i & ac_ready_o
- ac_row_i  in  ROW_W  dequantized AC row; lane 0 of row 0 is ignored
- out_valid_o  out  1  merged row valid
- out_ready_i  in  1  downstream ready
- out_row_o  out  ROW_W  merged row
- out_blk_o  out  3  block index: 0-3 Cb, 4-7 Cr; low 2 bits give DC raster index
- out_ridx_o  out  2  row index within the block
- out_mb_last_o  out  1  high on row 3 of block 7

Behaviour:
- **Reset** (async, rst_n_i low):
  - out_valid_o = 0, out_row_o = 0, out_blk_o = 0, out_ridx_o = 0, out_mb_last_o = 0.
  - Both bank-full flags = 0, blk_cnt = 0, row_cnt = 0.
  - Reset mid-block discards all partial state; the next accepted AC row is treated as block 0, row 0.
- **DC buffer:**
  - Two banks (Cb, Cr), each holding 4 x COEFF_W values plus a full flag.
  - dc_ready_o = !full[dc_comp_i].
  - On a DC handshake, the bank is written and its full flag set next cycle.
  - While Cb is being consumed, Cr may load, and vice versa.
- **AC acceptance:**
  - comp = blk_cnt[2].
  - ac_ready_o = (!out_valid_o | out_ready_i) & (row_cnt != 0 | full[comp]).
  - Row 0 of any block stalls until its bank is full. Rows 1-3 never wait on DC.
- **Merge:**
  - On an accepted row 0, out lane 0 = bank[comp][blk_cnt[1:0]]; lanes 1-3 pass through unchanged.
  - Rows 1-3 pass through unchanged. No arithmetic or saturation.
- **Latency:** exactly 1 cycle, accepted row to registered output. Output holds stable while out_valid_o & !out_ready_i.
- **Counters:**
  - row_cnt increments on each AC handshake and wraps 3 -> 0, then blk_cnt increments and wraps 7 -> 0.
  - When row 3 of block 3 is accepted, full[Cb] clears. When row 3 of block 7 is accepted, full[Cr] clears.
  - A clear and a DC write to the same bank cannot coincide, because dc_ready_o is low while that bank is full.
  - A clear on one bank and a write to the other bank in the same cycle are both honoured.
- **Throughput:** 1 row per cycle with no stall. A full chroma MB (32 rows) takes 32 cycles once both banks are loaded.
- **clr_i priority:** over all handshakes in the same cycle; the handshake is dropped.

Decomposition:
- tq_pkg holds:
  - COEFF_W
  - typedef coeff_t (signed [COEFF_W-1:0])
  - typedef row_t (array of 4 coeff_t)
  - constants CHROMA_BLKS = 8, ROWS_PER_BLK = 4.
- One sub-module, tq_dc_bank: one DC bank with its full flag and write/clear/read ports, instantiated twice.

Test Plan:
1. Reset, load Cb DC {100, -3, 7, 0} and Cr DC {-50, 1, 2, 3}, stream 32 rows of all-ones AC with out_ready_i = 1 -> 32 outputs at 1-cycle latency. Row 0 lane 0 of blocks 0-7 = 100, -3, 7, 0, -50, 1, 2, 3; every other lane = 1. out_mb_last_o high only on output 32.
2. Present AC row 0 before any DC -> ac_ready_o = 0 until the Cb DC handshake; first output appears 1 cycle after the following row acceptance.
3. Drop out_ready_i low for 3 cycles mid-block -> out_row_o and out_blk_o held stable, ac_ready_o = 0, no row lost or duplicated.
4. Present a second Cb DC set while Cb is full -> dc_ready_o = 0 until row 3 of block 3 is accepted. The new set is used for the next MB's block 0.
5. Assert rst_n_i asynchronously after 10 rows -> outputs 0 immediately, flags cleared. Reloading DC and streaming restarts at block 0, row 0.
6. Assert clr_i together with an AC handshake -> row dropped, counters 0, out_valid_o = 0 next cycle.
